// File: rtl/fcb_pkg.sv
// fcb_pkg: shared types for the FCB VLP request arbiter.
//   fcb_state_e   - arbiter FSM state encoding
//   REQ_PIN/REG/CLP - requester bit positions in the req_vlp_i / req_wu_i vectors
//   rr_next()     - advance a requester index by one, modulo 3
package fcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GRANT     = 3'd4,
    ST_TMO       = 3'd5
  } fcb_state_e;

  localparam logic [1:0] REQ_PIN = 2'd0;
  localparam logic [1:0] REQ_REG = 2'd1;
  localparam logic [1:0] REQ_CLP = 2'd2;

  // Index 3 is never a legal requester; it folds onto 0 like index 2 does.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_CLP) ? REQ_PIN : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fcb_vlp_req_arb_rr_arb3.sv
// rr_arb3: combinational 3-way round-robin picker.
//   req_i     [2:0] request vector
//   ptr_i     [1:0] highest-priority index; the search goes upward mod 3
//   win_oh_o  [2:0] one-hot winner, all zero when no request
//   win_idx_o [1:0] winner index, equal to the first candidate when no request
module rr_arb3
  import fcb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] win_oh_o,
  output logic [1:0] win_idx_o
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    cand0     = (ptr_i >= REQ_CLP) ? REQ_CLP : ptr_i;
    cand1     = rr_next(cand0);
    cand2     = rr_next(cand1);
    win_oh_o  = 3'b000;
    win_idx_o = cand0;
    if (req_i[cand0]) begin
      win_oh_o[cand0] = 1'b1;
      win_idx_o       = cand0;
    end else if (req_i[cand1]) begin
      win_oh_o[cand1] = 1'b1;
      win_idx_o       = cand1;
    end else if (req_i[cand2]) begin
      win_oh_o[cand2] = 1'b1;
      win_idx_o       = cand2;
    end
  end

endmodule

// File: rtl/fcb_vlp_req_arb.sv
// fcb_vlp_req_arb: arbitrates VLP-entry / wakeup requests from three
// requesters (pin MIC, register file, CLP) onto one PMU handshake.
//   fcb_sys_clk, fcb_sys_rst_n   clock, async active-low reset
//   req_vlp_i / req_wu_i [2:0]   request levels, eligible by vlp_state_o
//   fpmu_busy_i                  PMU busy; rise then fall completes an op
//   tmo_limit_i [TMO_W-1:0]      handshake timeout in cycles, 0 = off
//   clr_timeout_i                clears the sticky timeout flag
//   pmu_vlp_start_o / pmu_wu_start_o  one-cycle PMU start pulses
//   grant_o [2:0]                one-hot completion pulse to the winner
//   vlp_state_o                  1 while the chip is in VLP
//   timeout_o                    sticky handshake-timeout flag
//   dbg_state_o / dbg_cnt_o      FSM state and timeout counter for observation
//
// Handshake: requests are levels, sampled only in IDLE. Once a winner is
// latched the operation runs to completion regardless of the request level;
// the requester is acknowledged by a single-cycle grant_o pulse (or, on
// timeout, by nothing, with timeout_o set). The PMU side is start pulse ->
// busy rises -> busy falls.
module fcb_vlp_req_arb
  import fcb_pkg::*;
#(
  parameter int unsigned TMO_W = 8
) (
  input  logic             fcb_sys_clk,
  input  logic             fcb_sys_rst_n,
  input  logic [2:0]       req_vlp_i,
  input  logic [2:0]       req_wu_i,
  input  logic             fpmu_busy_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic             clr_timeout_i,
  output logic             pmu_vlp_start_o,
  output logic             pmu_wu_start_o,
  output logic [2:0]       grant_o,
  output logic             vlp_state_o,
  output logic             timeout_o,
  output fcb_state_e       dbg_state_o,
  output logic [TMO_W-1:0] dbg_cnt_o
);

  fcb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       win_oh_q, win_oh_d;
  logic [1:0]       win_idx_q, win_idx_d;
  logic             op_wu_q, op_wu_d;
  logic             vlp_q, vlp_d;
  logic             timeout_q, timeout_d;

  logic [2:0]       eligible;
  logic [2:0]       arb_oh;
  logic [1:0]       arb_idx;
  logic             tmo_hit;
  logic [TMO_W-1:0] cnt_inc;

  // Only the direction that makes sense for the current power state competes.
  assign eligible = vlp_q ? req_wu_i : req_vlp_i;

  rr_arb3 u_rr_arb3 (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .win_oh_o  (arb_oh),
    .win_idx_o (arb_idx)
  );

  assign tmo_hit = (tmo_limit_i != '0) && (cnt_q == tmo_limit_i);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    win_oh_d  = win_oh_q;
    win_idx_d = win_idx_q;
    op_wu_d   = op_wu_q;
    vlp_d     = vlp_q;
    timeout_d = timeout_q;

    // A timeout entry below overrides this clear in the same cycle.
    if (clr_timeout_i) timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          win_oh_d  = arb_oh;
          win_idx_d = arb_idx;
          op_wu_d   = vlp_q;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TMO;
        end else if (fpmu_busy_i) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TMO;
        end else if (!fpmu_busy_i) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        vlp_d   = ~vlp_q;
        ptr_d   = rr_next(win_idx_q);
        state_d = ST_IDLE;
      end
      ST_TMO: begin
        ptr_d   = rr_next(win_idx_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= REQ_PIN;
      cnt_q     <= '0;
      win_oh_q  <= 3'b000;
      win_idx_q <= REQ_PIN;
      op_wu_q   <= 1'b0;
      vlp_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      win_oh_q  <= win_oh_d;
      win_idx_q <= win_idx_d;
      op_wu_q   <= op_wu_d;
      vlp_q     <= vlp_d;
      timeout_q <= timeout_d;
    end
  end

  // All outputs decode flops only, so they cannot glitch on input changes.
  assign pmu_vlp_start_o = (state_q == ST_START) && !op_wu_q;
  assign pmu_wu_start_o  = (state_q == ST_START) &&  op_wu_q;
  assign grant_o         = (state_q == ST_GRANT) ? win_oh_q : 3'b000;
  assign vlp_state_o     = vlp_q;
  assign timeout_o       = timeout_q;
  assign dbg_state_o     = state_q;
  assign dbg_cnt_o       = cnt_q;

endmodule

// File: tb/tb_fcb_vlp_req_arb.sv
module tb_fcb_vlp_req_arb;
  import fcb_pkg::*;

  localparam int TMO_W = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req_vlp = 3'b000;
  logic [2:0]       req_wu = 3'b000;
  logic             busy = 1'b0;
  logic [TMO_W-1:0] tmo_limit = '0;
  logic             clr_tmo = 1'b0;

  logic             start_vlp;
  logic             start_wu;
  logic [2:0]       grant;
  logic             vlp_state;
  logic             timeout;
  fcb_state_e       dbg_state;
  logic [TMO_W-1:0] dbg_cnt;

  always #5 clk = ~clk;

  fcb_vlp_req_arb #(.TMO_W(TMO_W)) dut (
    .fcb_sys_clk     (clk),
    .fcb_sys_rst_n   (rst_n),
    .req_vlp_i       (req_vlp),
    .req_wu_i        (req_wu),
    .fpmu_busy_i     (busy),
    .tmo_limit_i     (tmo_limit),
    .clr_timeout_i   (clr_tmo),
    .pmu_vlp_start_o (start_vlp),
    .pmu_wu_start_o  (start_wu),
    .grant_o         (grant),
    .vlp_state_o     (vlp_state),
    .timeout_o       (timeout),
    .dbg_state_o     (dbg_state),
    .dbg_cnt_o       (dbg_cnt)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every grant pulse must match the next expected grant, in order.
  always @(negedge clk) begin
    if (rst_n && grant != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 32'(grant), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("grant_order", 32'(grant), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Step one cycle; returns at the falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_vlp"}, 32'(start_vlp), 32'd0);
    chk({tag, "_start_wu"},  32'(start_wu),  32'd0);
    chk({tag, "_grant"},     32'(grant),     32'd0);
    chk({tag, "_vlp_state"}, 32'(vlp_state), 32'd0);
    chk({tag, "_timeout"},   32'(timeout),   32'd0);
    chk({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_cnt"},       32'(dbg_cnt),   32'd0);
  endtask

  // Caller has a request on the eligible vector; DUT is in IDLE.
  task automatic run_handshake(input string tag, input int busy_len,
                               input logic exp_wu, input logic [2:0] exp_gnt);
    int exp_cnt;
    exp_cnt = (busy_len > 255) ? 255 : busy_len;
    exp_q.push_back(exp_gnt);
    tick();
    chk({tag, "_start_vlp"}, 32'(start_vlp), 32'(!exp_wu));
    chk({tag, "_start_wu"},  32'(start_wu),  32'(exp_wu));
    tick();
    busy = 1'b1;
    repeat (busy_len) tick();
    chk({tag, "_wait_done"}, 32'(dbg_state), 32'(ST_WAIT_DONE));
    chk({tag, "_cnt"},       32'(dbg_cnt),   32'(exp_cnt));
    chk({tag, "_no_grant"},  32'(grant),     32'd0);
    busy = 1'b0;
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
    tick();
    chk({tag, "_grant_end"}, 32'(grant),     32'd0);
    chk({tag, "_idle"},      32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // single VLP entry from pin MIC with exact cycle timing; request is
    // withdrawn right after the start pulse and the grant still arrives
    req_vlp = 3'b001;
    exp_q.push_back(3'b001);
    tick();                                       // cycle N+1
    chk("t1_start_vlp", 32'(start_vlp), 32'd1);
    chk("t1_start_wu",  32'(start_wu),  32'd0);
    req_vlp = 3'b000;
    tick();                                       // N+2
    chk("t1_start_end", 32'(start_vlp), 32'd0);
    chk("t1_wait_busy", 32'(dbg_state), 32'(ST_WAIT_BUSY));
    tick();                                       // N+3
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();                                     // N+4 .. N+7
      chk("t1_no_grant", 32'(grant), 32'd0);
    end
    busy = 1'b0;
    tick();                                       // N+8
    chk("t1_grant",     32'(grant),     32'h1);
    chk("t1_vlp_pre",   32'(vlp_state), 32'd0);
    tick();                                       // N+9
    chk("t1_grant_end", 32'(grant),     32'd0);
    chk("t1_vlp_state", 32'(vlp_state), 32'd1);

    // fresh reset, then three operations with all requests held
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("rst2");
    rst_n = 1'b1;
    req_vlp = 3'b111;
    req_wu  = 3'b111;
    run_handshake("t2a", 2, 1'b0, 3'b001);
    run_handshake("t2b", 3, 1'b1, 3'b010);
    run_handshake("t2c", 1, 1'b0, 3'b100);
    req_vlp = 3'b000;
    req_wu  = 3'b000;
    chk("t2_vlp_state", 32'(vlp_state), 32'd1);

    // in VLP, VLP requests are ignored; a CLP wakeup goes through
    req_vlp = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_start", 32'({start_vlp, start_wu}), 32'd0);
      chk("t3_idle",     32'(dbg_state), 32'(ST_IDLE));
    end
    req_wu = 3'b100;
    run_handshake("t3", 2, 1'b1, 3'b100);
    req_vlp = 3'b000;
    req_wu  = 3'b000;
    chk("t3_vlp_state", 32'(vlp_state), 32'd0);

    // timeout: limit 5, PMU never busy; a clear in the entry cycle loses
    tmo_limit = 8'd5;
    req_vlp = 3'b010;
    tick();
    chk("t4_start_vlp", 32'(start_vlp), 32'd1);
    req_vlp = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_wait_busy", 32'(dbg_state), 32'(ST_WAIT_BUSY));
      chk("t4_cnt",       32'(dbg_cnt),   32'(i));
      chk("t4_tmo_low",   32'(timeout),   32'd0);
      if (i == 5) clr_tmo = 1'b1;
    end
    tick();
    clr_tmo = 1'b0;
    chk("t4_tmo_state", 32'(dbg_state), 32'(ST_TMO));
    chk("t4_tmo_set",   32'(timeout),   32'd1);
    chk("t4_no_grant",  32'(grant),     32'd0);
    tick();
    chk("t4_idle",      32'(dbg_state), 32'(ST_IDLE));
    chk("t4_tmo_held",  32'(timeout),   32'd1);
    chk("t4_vlp_same",  32'(vlp_state), 32'd0);

    // arbitration continues with the flag set; pointer moved past requester 1
    req_vlp = 3'b111;
    run_handshake("t4b", 2, 1'b0, 3'b100);
    req_vlp = 3'b000;
    chk("t4b_tmo_held",  32'(timeout),   32'd1);
    chk("t4b_vlp_state", 32'(vlp_state), 32'd1);
    clr_tmo = 1'b1;
    tick();
    clr_tmo = 1'b0;
    chk("t4_tmo_clr", 32'(timeout), 32'd0);
    tmo_limit = '0;

    // move the pointer off 0, then reset in WAIT_DONE
    req_wu = 3'b001;
    run_handshake("t5a", 1, 1'b1, 3'b001);
    req_wu = 3'b000;
    req_vlp = 3'b100;
    tick();
    chk("t5_start_vlp", 32'(start_vlp), 32'd1);
    req_vlp = 3'b000;
    tick();
    busy = 1'b1;
    tick();
    tick();
    chk("t5_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    rst_n = 1'b0;
    tick();
    busy = 1'b0;
    chk_reset_outputs("t5_rst");
    rst_n = 1'b1;
    tick();
    chk("t5_no_grant", 32'(grant), 32'd0);
    req_vlp = 3'b111;
    run_handshake("t5b", 1, 1'b0, 3'b001);
    req_vlp = 3'b000;

    // timeout disabled, long busy: counter saturates, grant still issued
    req_wu = 3'b010;
    run_handshake("t6", 300, 1'b1, 3'b010);
    req_wu = 3'b000;
    chk("t6_no_tmo",    32'(timeout),   32'd0);
    chk("t6_vlp_state", 32'(vlp_state), 32'd0);

    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
